// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: forwarding select codes,
// controller FSM states and the scoreboard entry tracked per pipeline stage.
package pipe_hazard_ctrl_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       rf_wb;
        logic       is_load;
    } sb_entry_t;

    // A stage feeds a decode source only if it really writes a nonzero register
    // that the decode instruction actually reads.
    function automatic logic src_match(input sb_entry_t e, input logic [4:0] rs,
                                       input logic use_rs);
        return e.valid && e.rf_wb && (e.rd != 5'd0) && (e.rd == rs) && use_rs;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_scoreboard.sv
// Three-stage destination scoreboard (EX, MEM, WB) that mirrors the pipeline
// registers; stall or flush load a bubble into EX while MEM/WB keep draining.
module hazard_scoreboard
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       dec_valid,
    input  logic [4:0] dec_rd,
    input  logic       dec_rf_wb,
    input  logic       dec_is_load,
    input  logic       stall,
    input  logic       flush,
    output sb_entry_t  ex_entry,
    output sb_entry_t  mem_entry,
    output sb_entry_t  wb_entry
);

    sb_entry_t dec_entry;

    always_comb begin
        dec_entry         = '0;
        dec_entry.valid   = dec_valid;
        dec_entry.rd      = dec_rd;
        dec_entry.rf_wb   = dec_rf_wb;
        dec_entry.is_load = dec_is_load;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_entry  <= '0;
            mem_entry <= '0;
            wb_entry  <= '0;
        end else begin
            // The decode instruction is held (stall) or squashed (flush); either
            // way nothing real enters EX this edge.
            ex_entry  <= (stall || flush) ? sb_entry_t'('0) : dec_entry;
            mem_entry <= ex_entry;
            wb_entry  <= mem_entry;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: RUN/STALL/FLUSH FSM, zero-cycle hazard detection,
// operand forwarding selects and saturating stall/flush counters.
// Build option HAZARD_FWD_EN: with forwarding only load-use in EX stalls;
// without it any EX/MEM/WB producer match stalls and forwarding stays at regfile.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dec_valid,
    input  logic [4:0]       dec_rs1,
    input  logic [4:0]       dec_rs2,
    input  logic             dec_use_rs1,
    input  logic             dec_use_rs2,
    input  logic [4:0]       dec_rd,
    input  logic             dec_rf_wb,
    input  logic             dec_is_load,
    input  logic             pc_src_mem,
    output logic             stall_if,
    output logic             stall_dec,
    output logic             flush_dec,
    output logic             flush_ex,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [1:0]       fsm_state
);

    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;
    localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES);

    state_t          state, state_nx;
    logic [FC_W-1:0] fcnt, fcnt_nx;

    sb_entry_t ex_entry, mem_entry, wb_entry;

    logic       ex_a, ex_b, mem_a, mem_b;
    logic       hazard;
    logic [1:0] fwd_a_raw, fwd_b_raw;
    logic       flush_dec_i, flush_ex_i, stall_i;

    hazard_scoreboard u_sb (
        .clk         (clk),
        .rst         (rst),
        .dec_valid   (dec_valid),
        .dec_rd      (dec_rd),
        .dec_rf_wb   (dec_rf_wb),
        .dec_is_load (dec_is_load),
        .stall       (stall_i),
        .flush       (flush_dec_i),
        .ex_entry    (ex_entry),
        .mem_entry   (mem_entry),
        .wb_entry    (wb_entry)
    );

    assign ex_a  = src_match(ex_entry,  dec_rs1, dec_use_rs1);
    assign ex_b  = src_match(ex_entry,  dec_rs2, dec_use_rs2);
    assign mem_a = src_match(mem_entry, dec_rs1, dec_use_rs1);
    assign mem_b = src_match(mem_entry, dec_rs2, dec_use_rs2);

`ifdef HAZARD_FWD_EN
    logic unused_fwd;
    assign unused_fwd = ^{mem_entry.is_load, wb_entry};

    // Load data is not ready until MEM ends, so only a load in EX must wait.
    assign hazard = dec_valid && ex_entry.is_load && (ex_a || ex_b);

    always_comb begin
        fwd_a_raw = FWD_RF;
        fwd_b_raw = FWD_RF;
        if (ex_a && !ex_entry.is_load) fwd_a_raw = FWD_EX;
        else if (mem_a)                fwd_a_raw = FWD_MEM;
        if (ex_b && !ex_entry.is_load) fwd_b_raw = FWD_EX;
        else if (mem_b)                fwd_b_raw = FWD_MEM;
    end
`else
    logic wb_a, wb_b;
    logic unused_nofwd;
    assign unused_nofwd = ^{ex_entry.is_load, mem_entry.is_load, wb_entry.is_load};

    assign wb_a   = src_match(wb_entry, dec_rs1, dec_use_rs1);
    assign wb_b   = src_match(wb_entry, dec_rs2, dec_use_rs2);
    assign hazard = dec_valid && (ex_a || ex_b || mem_a || mem_b || wb_a || wb_b);

    assign fwd_a_raw = FWD_RF;
    assign fwd_b_raw = FWD_RF;
`endif

    // Flush outranks stall: a redirected decode slot is discarded, never held.
    assign flush_ex_i  = pc_src_mem;
    assign flush_dec_i = pc_src_mem || (state == FLUSH);
    assign stall_i     = hazard && !flush_dec_i;

    always_comb begin
        state_nx = state;
        fcnt_nx  = fcnt;
        if (pc_src_mem) begin
            fcnt_nx  = FC_LOAD;
            state_nx = (FLUSH_CYCLES > 0) ? FLUSH : RUN;
        end else begin
            case (state)
                RUN: begin
                    if (hazard) state_nx = STALL;
                end
                STALL: begin
                    if (!hazard) state_nx = RUN;
                end
                FLUSH: begin
                    if (fcnt <= FC_W'(1)) begin
                        fcnt_nx  = '0;
                        state_nx = RUN;
                    end else begin
                        fcnt_nx = fcnt - FC_W'(1);
                    end
                end
                default: begin
                    fcnt_nx  = '0;
                    state_nx = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            fcnt  <= '0;
        end else begin
            state <= state_nx;
            fcnt  <= fcnt_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_i && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (pc_src_mem && (flush_cnt != {CNT_W{1'b1}}))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    // The dec_* and pc_src_mem paths are combinational, so mask them in reset.
    assign stall_if  = !rst && stall_i;
    assign stall_dec = !rst && stall_i;
    assign flush_dec = !rst && flush_dec_i;
    assign flush_ex  = !rst && flush_ex_i;
    assign fwd_a_sel = rst ? FWD_RF : fwd_a_raw;
    assign fwd_b_sel = rst ? FWD_RF : fwd_b_raw;
    assign fsm_state = state;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: per-cycle expected outputs are queued by
// the driver and checked by a negedge monitor; a CNT_W=4 copy checks saturation.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       dec_valid, dec_use_rs1, dec_use_rs2, dec_rf_wb, dec_is_load, pc_src_mem;
    logic [4:0] dec_rs1, dec_rs2, dec_rd;

    logic        stall_if, stall_dec, flush_dec, flush_ex;
    logic [1:0]  fwd_a_sel, fwd_b_sel, fsm_state;
    logic [15:0] stall_cnt, flush_cnt;

    logic        stall_if4, stall_dec4, flush_dec4, flush_ex4;
    logic [1:0]  fwd_a_sel4, fwd_b_sel4, fsm_state4;
    logic [3:0]  stall_cnt4, flush_cnt4;

    // Expected word: {state, stall_if, stall_dec, flush_dec, flush_ex, fwd_a, fwd_b,
    //                 stall_cnt, flush_cnt, stall_cnt4, flush_cnt4}
    logic [49:0] exp_q[$];
    string       name_q[$];
    int          total = 0;
    int          bad   = 0;
    int          s16 = 0, f16 = 0, s4 = 0, f4 = 0;

    localparam logic [9:0] I_R    = 10'h000;
    localparam logic [9:0] I_S    = 10'h100;
    localparam logic [9:0] S_R    = 10'h0C0;
    localparam logic [9:0] S_S    = 10'h1C0;
    localparam logic [9:0] F_R    = 10'h030;
    localparam logic [9:0] F_S    = 10'h130;
    localparam logic [9:0] F_F    = 10'h230;
    localparam logic [9:0] D_F    = 10'h220;
    localparam logic [9:0] FA_EX  = 10'h004;
    localparam logic [9:0] FA_MEM = 10'h008;
    localparam logic [9:0] FB_EX  = 10'h001;
    localparam logic [9:0] FB_MEM = 10'h002;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2), .dec_rd(dec_rd),
        .dec_rf_wb(dec_rf_wb), .dec_is_load(dec_is_load), .pc_src_mem(pc_src_mem),
        .stall_if(stall_if), .stall_dec(stall_dec), .flush_dec(flush_dec), .flush_ex(flush_ex),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt), .fsm_state(fsm_state)
    );

    pipe_hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2), .dec_rd(dec_rd),
        .dec_rf_wb(dec_rf_wb), .dec_is_load(dec_is_load), .pc_src_mem(pc_src_mem),
        .stall_if(stall_if4), .stall_dec(stall_dec4), .flush_dec(flush_dec4), .flush_ex(flush_ex4),
        .fwd_a_sel(fwd_a_sel4), .fwd_b_sel(fwd_b_sel4), .stall_cnt(stall_cnt4),
        .flush_cnt(flush_cnt4), .fsm_state(fsm_state4)
    );

    // Driver: apply one cycle of inputs just after the rising edge and queue the
    // outputs expected for that cycle. Counter expectations lag by one edge.
    task automatic step(input logic r, input logic dv, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic u1, input logic u2,
                        input logic [4:0] rd, input logic wb, input logic ld,
                        input logic pc, input logic [9:0] ctl, input string nm);
        rst = r; dec_valid = dv; dec_rs1 = rs1; dec_rs2 = rs2;
        dec_use_rs1 = u1; dec_use_rs2 = u2; dec_rd = rd; dec_rf_wb = wb;
        dec_is_load = ld; pc_src_mem = pc;
        if (r) begin
            s16 = 0; f16 = 0; s4 = 0; f4 = 0;
        end
        exp_q.push_back({ctl, 16'(s16), 16'(f16), 4'(s4), 4'(f4)});
        name_q.push_back(nm);
        if (!r) begin
            if (ctl[7]) begin
                s16++;
                if (s4 < 15) s4++;
            end
            if (pc) begin
                f16++;
                if (f4 < 15) f4++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic nop(input logic [9:0] ctl, input string nm);
        step(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, ctl, nm);
    endtask

    task automatic prod(input logic [4:0] rd, input logic ld, input logic [9:0] ctl,
                        input string nm);
        step(1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, rd, 1'b1, ld, 1'b0, ctl, nm);
    endtask

    task automatic usr(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                       input logic u2, input logic pc, input logic [9:0] ctl,
                       input string nm);
        step(1'b0, 1'b1, rs1, rs2, u1, u2, 5'd0, 1'b0, 1'b0, pc, ctl, nm);
    endtask

    task automatic redirect(input logic [9:0] ctl, input string nm);
        step(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, ctl, nm);
    endtask

    // Monitor: every cycle the design presents one output vector.
    always @(negedge clk) begin
        logic [49:0] act, want;
        string nm;
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            nm   = name_q.pop_front();
            act  = {fsm_state, stall_if, stall_dec, flush_dec, flush_ex, fwd_a_sel, fwd_b_sel,
                    stall_cnt, flush_cnt, stall_cnt4, flush_cnt4};
            total++;
            if (act !== want) begin
                bad++;
                $display("FAIL %s: got st=%0d ctl=%b sc=%0d fc=%0d sc4=%0d fc4=%0d, want st=%0d ctl=%b sc=%0d fc=%0d sc4=%0d fc4=%0d",
                         nm, act[49:48], act[47:40], act[39:24], act[23:8], act[7:4], act[3:0],
                         want[49:48], want[47:40], want[39:24], want[23:8], want[7:4], want[3:0]);
            end
        end
    end

    initial begin
        rst = 1'b1; dec_valid = 1'b0; dec_rs1 = '0; dec_rs2 = '0; dec_use_rs1 = 1'b0;
        dec_use_rs2 = 1'b0; dec_rd = '0; dec_rf_wb = 1'b0; dec_is_load = 1'b0;
        pc_src_mem = 1'b0;
        @(posedge clk);
        #1;

        step(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, I_R, "reset");
        step(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, I_R, "reset_pc_masked");
        nop(I_R, "after_reset");

`ifdef HAZARD_FWD_EN
        prod(5'd5, 1'b1, I_R, "lu_load");
        usr(5'd5, 5'd0, 1'b1, 1'b0, 1'b0, S_R, "lu_stall");
        usr(5'd5, 5'd0, 1'b1, 1'b0, 1'b0, I_S | FA_MEM, "lu_fwd_mem");
        nop(I_R, "lu_done");
        prod(5'd7, 1'b0, I_R, "alu_rd7");
        usr(5'd0, 5'd7, 1'b0, 1'b1, 1'b0, FB_EX, "fwd_b_ex");
        prod(5'd0, 1'b0, I_R, "alu_rd0");
        usr(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, I_R, "fwd_b_rd0");
        prod(5'd8, 1'b0, I_R, "ex_pri_1");
        prod(5'd8, 1'b0, I_R, "ex_pri_2");
        usr(5'd8, 5'd0, 1'b1, 1'b0, 1'b0, FA_EX, "fwd_a_ex_over_mem");
        prod(5'd14, 1'b0, I_R, "mem_prod");
        nop(I_R, "mem_gap");
        usr(5'd0, 5'd14, 1'b0, 1'b1, 1'b0, FB_MEM, "fwd_b_mem");
        nop(I_R, "mem_done");
`else
        prod(5'd3, 1'b0, I_R, "raw_prod");
        usr(5'd3, 5'd0, 1'b1, 1'b0, 1'b0, S_R, "raw_stall1");
        usr(5'd3, 5'd0, 1'b1, 1'b0, 1'b0, S_S, "raw_stall2");
        usr(5'd3, 5'd0, 1'b1, 1'b0, 1'b0, S_S, "raw_stall3");
        usr(5'd3, 5'd0, 1'b1, 1'b0, 1'b0, I_S, "raw_release");
        nop(I_R, "raw_run");
        prod(5'd14, 1'b0, I_R, "mem_prod");
        nop(I_R, "mem_gap");
        usr(5'd0, 5'd14, 1'b0, 1'b1, 1'b0, S_R, "mem_stall1");
        usr(5'd0, 5'd14, 1'b0, 1'b1, 1'b0, S_S, "mem_stall2");
        usr(5'd0, 5'd14, 1'b0, 1'b1, 1'b0, I_S, "mem_release");
        nop(I_R, "mem_done");
`endif

        prod(5'd9, 1'b0, I_R, "nouse_prod");
        usr(5'd9, 5'd9, 1'b0, 1'b0, 1'b0, I_R, "nouse_no_stall");
        prod(5'd0, 1'b0, I_R, "x0_prod");
        usr(5'd0, 5'd0, 1'b1, 1'b1, 1'b0, I_R, "x0_no_stall");
        step(1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd12, 1'b0, 1'b0, 1'b0, I_R, "nowb_prod");
        usr(5'd0, 5'd12, 1'b0, 1'b1, 1'b0, I_R, "nowb_no_stall");
        step(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd13, 1'b1, 1'b0, 1'b0, I_R, "inval_prod");
        usr(5'd13, 5'd0, 1'b1, 1'b0, 1'b0, I_R, "inval_no_stall");
        nop(I_R, "drain1");
        nop(I_R, "drain2");

        // Redirect arriving during a stall.
`ifdef HAZARD_FWD_EN
        prod(5'd20, 1'b1, I_R, "fl_load");
        usr(5'd20, 5'd0, 1'b1, 1'b0, 1'b0, S_R, "fl_stall");
        usr(5'd20, 5'd0, 1'b1, 1'b0, 1'b1, F_S | FA_MEM, "fl_redirect");
`else
        prod(5'd20, 1'b0, I_R, "fl_prod");
        usr(5'd20, 5'd0, 1'b1, 1'b0, 1'b0, S_R, "fl_stall");
        usr(5'd20, 5'd0, 1'b1, 1'b0, 1'b1, F_S, "fl_redirect");
`endif
        usr(5'd20, 5'd0, 1'b1, 1'b0, 1'b0, D_F, "fl_hold");
        nop(I_R, "fl_run");

        redirect(F_R, "reload_1");
        redirect(F_F, "reload_2");
        nop(D_F, "reload_hold");
        nop(I_R, "reload_run");

        prod(5'd21, 1'b1, I_R, "rst_prod");
        redirect(F_R, "rst_flush");
        step(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, I_R, "rst_mid_flush");
        usr(5'd21, 5'd0, 1'b1, 1'b0, 1'b0, I_R, "rst_clean_run");
        nop(I_R, "rst_idle");

`ifdef HAZARD_FWD_EN
        for (int k = 1; k <= 21; k++) begin
            prod(5'(k), 1'b1, I_R, "sat_load");
            usr(5'(k), 5'd0, 1'b1, 1'b0, 1'b0, S_R, "sat_stall");
            usr(5'(k), 5'd0, 1'b1, 1'b0, 1'b0, I_S | FA_MEM, "sat_fwd");
        end
`else
        for (int k = 1; k <= 7; k++) begin
            prod(5'(k), 1'b0, I_R, "sat_prod");
            usr(5'(k), 5'd0, 1'b1, 1'b0, 1'b0, S_R, "sat_stall1");
            usr(5'(k), 5'd0, 1'b1, 1'b0, 1'b0, S_S, "sat_stall2");
            usr(5'(k), 5'd0, 1'b1, 1'b0, 1'b0, S_S, "sat_stall3");
            usr(5'(k), 5'd0, 1'b1, 1'b0, 1'b0, I_S, "sat_release");
        end
`endif
        nop(I_R, "sat_stall_done");

        redirect(F_R, "fsat_first");
        for (int k = 0; k < 16; k++) redirect(F_F, "fsat_more");
        nop(D_F, "fsat_hold");
        nop(I_R, "fsat_run");
        nop(I_R, "final");

        repeat (2) @(posedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
